// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D round-robin sequencer.
// Pure declarations; no latency.
// No flow control of its own.
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WAIT_CMD,
        SETTLE,
        READ,
        WAIT_RD,
        NEXT
    } state_t;

    // Sequencer index 0..3 -> physical A2D channel (channel 2 is unused on the bike)
    localparam logic [3:0][2:0] CHNL_MAP = {3'd4, 3'd3, 3'd1, 3'd0};

    localparam int PERIOD_W_FAST = 10;
    localparam int PERIOD_W_SLOW = 14;

    localparam logic [7:0] WDOG_LIMIT = 8'hFF;

    function automatic int period_w(input int fast_sim);
        return (fast_sim != 0) ? PERIOD_W_FAST : PERIOD_W_SLOW;
    endfunction

    function automatic logic [15:0] build_cmd(input logic [1:0] idx);
        return {2'b00, CHNL_MAP[idx], 11'h000};
    endfunction

endpackage

// File: rtl/a2d_sequencer.sv
// Round-robin SPI A2D scheduler: one 4-channel round per period tick; A2D_TIMEOUT_EN adds a done watchdog.
// Latency: wrt 1 clk after tick; result register updates the clock after the read done.
// Backpressure: waits on SPI done per transaction (forever unless A2D_TIMEOUT_EN).
module a2d_sequencer
    import a2d_pkg::*;
#(
    parameter int FAST_SIM   = 1,
    parameter int SETTLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        done,
    input  logic [15:0] resp,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque,
    output logic        round_done,
    output logic        a2d_err
);

    localparam int         PW          = period_w(FAST_SIM);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t        state;
    logic [PW-1:0] period_cnt;
    logic          tick;
    logic [1:0]    idx;
    logic [3:0]    settle_cnt;
    logic          unused_resp_hi;

    assign tick           = &period_cnt;
    assign unused_resp_hi = ^resp[15:12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

`ifdef A2D_TIMEOUT_EN
    logic [7:0] wdog;
    logic       err_q;
    assign a2d_err = err_q;
`else
    assign a2d_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            settle_cnt <= 4'd0;
            wrt        <= 1'b0;
            cmd        <= 16'h0000;
            batt       <= 12'h000;
            curr       <= 12'h000;
            brake      <= 12'h000;
            torque     <= 12'h000;
            round_done <= 1'b0;
`ifdef A2D_TIMEOUT_EN
            wdog       <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            wrt        <= 1'b0;
            round_done <= 1'b0;
`ifdef A2D_TIMEOUT_EN
            wdog       <= 8'd0;
`endif
            case (state)
                IDLE: begin
                    if (tick) begin
                        wrt   <= 1'b1;
                        cmd   <= build_cmd(idx);
                        state <= CMD;
                    end
                end
                CMD: state <= WAIT_CMD;
                WAIT_CMD: begin
                    if (done) begin
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
`ifdef A2D_TIMEOUT_EN
                    else if (wdog == WDOG_LIMIT) begin
                        err_q <= 1'b1;
                        state <= NEXT;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
`endif
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        wrt   <= 1'b1;
                        state <= READ;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                READ: state <= WAIT_RD;
                WAIT_RD: begin
                    if (done) begin
                        case (idx)
                            2'd0:    batt   <= resp[11:0];
                            2'd1:    curr   <= resp[11:0];
                            2'd2:    brake  <= resp[11:0];
                            default: torque <= resp[11:0];
                        endcase
                        state <= NEXT;
                    end
`ifdef A2D_TIMEOUT_EN
                    else if (wdog == WDOG_LIMIT) begin
                        err_q <= 1'b1;
                        state <= NEXT;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
`endif
                end
                NEXT: begin
                    if (idx == 2'd3) begin
                        round_done <= 1'b1;
                        idx        <= 2'd0;
                        state      <= IDLE;
                    end else begin
                        idx   <= idx + 2'd1;
                        wrt   <= 1'b1;
                        cmd   <= build_cmd(idx + 2'd1);
                        state <= CMD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_sequencer.sv
// Directed bench for a2d_sequencer with a behavioural SPI/A2D responder.
// Timeout round runs only when A2D_TIMEOUT_EN is defined.
// Responder answers every wrt after a fixed latency unless its channel is muted.
module tb_a2d_sequencer;

    localparam int LAT = 20;

    logic        clk;
    logic        rst_n;
    logic        done;
    logic [15:0] resp;
    logic        wrt;
    logic [15:0] cmd;
    logic [11:0] batt, curr, brake, torque;
    logic        round_done;
    logic        a2d_err;

    logic        model_done, model_is_read, spur_done;
    logic [15:0] model_resp;
    logic [15:0] resp_tab [8];
    int          mute_ch;

    int          n_chk = 0;
    int          n_bad = 0;

    int          cyc = 0;
    int          last_done_cyc = 0;
    int          wrt_cnt = 0;
    int          rd_cnt = 0;
    logic [15:0] wrt_cmd [64];
    int          wrt_cyc [64];
    int          wrt_gap [64];

    logic [15:0] exp_cmd [4];

    assign done = model_done | spur_done;
    assign resp = spur_done ? 16'h0EEE : model_resp;

    a2d_sequencer #(.FAST_SIM(1), .SETTLE_CYC(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .done       (done),
        .resp       (resp),
        .wrt        (wrt),
        .cmd        (cmd),
        .batt       (batt),
        .curr       (curr),
        .brake      (brake),
        .torque     (torque),
        .round_done (round_done),
        .a2d_err    (a2d_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // SPI slave model: a repeated select of the same channel is the read
    initial begin : spi_model
        int       cnt;
        logic     have_last, last_rd;
        logic [2:0] last_ch, ch;
        cnt = 0; have_last = 1'b0; last_rd = 1'b0; last_ch = 3'd0;
        model_done = 1'b0; model_resp = 16'h0000; model_is_read = 1'b0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (!rst_n) begin
                cnt = 0;
                have_last = 1'b0;
            end else if (wrt) begin
                ch        = cmd[13:11];
                last_rd   = have_last && !last_rd && (ch == last_ch);
                last_ch   = ch;
                have_last = 1'b1;
                cnt       = (mute_ch == int'(ch)) ? 0 : LAT;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    model_done    = 1'b1;
                    model_is_read = last_rd;
                    model_resp    = last_rd ? resp_tab[last_ch] : 16'hC0DE;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (model_done) last_done_cyc = cyc;
        if (wrt) begin
            wrt_cmd[wrt_cnt % 64] = cmd;
            wrt_cyc[wrt_cnt % 64] = cyc;
            wrt_gap[wrt_cnt % 64] = cyc - last_done_cyc;
            wrt_cnt++;
        end
        if (round_done) rd_cnt++;
    end

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_wrt"},        {31'd0, wrt}, 32'd0);
        chk_eq({tag, "_cmd"},        {16'd0, cmd}, 32'd0);
        chk_eq({tag, "_batt"},       {20'd0, batt}, 32'd0);
        chk_eq({tag, "_curr"},       {20'd0, curr}, 32'd0);
        chk_eq({tag, "_brake"},      {20'd0, brake}, 32'd0);
        chk_eq({tag, "_torque"},     {20'd0, torque}, 32'd0);
        chk_eq({tag, "_round_done"}, {31'd0, round_done}, 32'd0);
        chk_eq({tag, "_a2d_err"},    {31'd0, a2d_err}, 32'd0);
    endtask

    // Called right after a negedge reset release; the tick lands on posedge 1024
    task automatic wait_first_wrt(input string tag);
        int k;
        k = 0;
        for (int i = 1; i <= 1100 && k == 0; i++) begin
            @(posedge clk); #2;
            if (wrt) k = i;
        end
        chk_eq({tag, "_first_wrt_lat"}, k, 32'd1024);
        chk_eq({tag, "_first_cmd"}, {16'd0, cmd}, 32'h0000);
    endtask

    task automatic wait_round(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #2;
            if (round_done) ok = 1'b1;
        end
        chk_eq({tag, "_round_done_seen"}, {31'd0, ok}, 32'd1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic chk_regs(input string tag, input logic [11:0] eb, input logic [11:0] ec,
                            input logic [11:0] ek, input logic [11:0] et);
        chk_eq({tag, "_batt"},   {20'd0, batt},   {20'd0, eb});
        chk_eq({tag, "_curr"},   {20'd0, curr},   {20'd0, ec});
        chk_eq({tag, "_brake"},  {20'd0, brake},  {20'd0, ek});
        chk_eq({tag, "_torque"}, {20'd0, torque}, {20'd0, et});
    endtask

    initial begin : main
        int   base, rb, err_cyc;
        logic found;
        exp_cmd[0] = 16'h0000; exp_cmd[1] = 16'h0800;
        exp_cmd[2] = 16'h1800; exp_cmd[3] = 16'h2000;
        rst_n = 1'b0; spur_done = 1'b0; mute_ch = -1;
        for (int i = 0; i < 8; i++) resp_tab[i] = 16'h0000;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");

        // Round 1: upper nibble of resp must be dropped
        resp_tab[0] = 16'hFABC; resp_tab[1] = 16'h1555;
        resp_tab[3] = 16'h2777; resp_tab[4] = 16'h3999;
        @(negedge clk); rst_n = 1'b1;
        wait_first_wrt("r1");
        wait_round("r1");
        chk_regs("r1", 12'hABC, 12'h555, 12'h777, 12'h999);

        // Round 2: full round, command words, pulse counts, settle gap
        resp_tab[0] = 16'h0111; resp_tab[1] = 16'h0222;
        resp_tab[3] = 16'h0333; resp_tab[4] = 16'h0444;
        base = wrt_cnt; rb = rd_cnt;
        wait_round("r2");
        chk_regs("r2", 12'h111, 12'h222, 12'h333, 12'h444);
        chk_eq("r2_wrt_pulses", wrt_cnt - base, 32'd8);
        chk_eq("r2_round_done_pulses", rd_cnt - rb, 32'd1);
        for (int c = 0; c < 4; c++) begin
            chk_eq($sformatf("r2_cmd_sel%0d", c), {16'd0, wrt_cmd[(base + 2*c) % 64]}, {16'd0, exp_cmd[c]});
            chk_eq($sformatf("r2_cmd_rd%0d", c), {16'd0, wrt_cmd[(base + 2*c + 1) % 64]}, {16'd0, exp_cmd[c]});
            chk_eq($sformatf("r2_settle_gap%0d", c), wrt_gap[(base + 2*c + 1) % 64], 32'd4);
        end

        // Spurious done while idle
        base = wrt_cnt; rb = rd_cnt;
        @(negedge clk); spur_done = 1'b1;
        @(negedge clk); spur_done = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_regs("idle_spur", 12'h111, 12'h222, 12'h333, 12'h444);
        chk_eq("idle_spur_wrt", wrt_cnt - base, 32'd0);
        chk_eq("idle_spur_round_done", rd_cnt - rb, 32'd0);

        // Round 3: spurious done during channel-0 settle
        resp_tab[0] = 16'h0155; resp_tab[1] = 16'h1255;
        resp_tab[3] = 16'h2355; resp_tab[4] = 16'h3455;
        base = wrt_cnt;
        found = 1'b0;
        for (int i = 0; i < 1500 && !found; i++) begin
            @(posedge clk); #2;
            if (model_done && !model_is_read) found = 1'b1;
        end
        chk_eq("settle_spur_found", {31'd0, found}, 32'd1);
        @(negedge clk); spur_done = 1'b1;
        @(negedge clk); spur_done = 1'b0;
        wait_round("r3");
        chk_regs("r3", 12'h155, 12'h255, 12'h355, 12'h455);
        chk_eq("r3_settle_gap", wrt_gap[(base + 1) % 64], 32'd4);
        chk_eq("r3_wrt_pulses", wrt_cnt - base, 32'd8);

`ifdef A2D_TIMEOUT_EN
        // Timeout round: channel 1 never answers
        mute_ch = 1;
        resp_tab[0] = 16'h71A1; resp_tab[1] = 16'h72A2;
        resp_tab[3] = 16'h73A3; resp_tab[4] = 16'h74A4;
        base = wrt_cnt;
        err_cyc = 0;
        for (int i = 0; i < 3000 && err_cyc == 0; i++) begin
            @(posedge clk); #2;
            if (a2d_err) err_cyc = cyc;
        end
        chk_eq("to_err_seen", {31'd0, a2d_err}, 32'd1);
        chk_eq("to_err_delay_window",
               {31'd0, (err_cyc - wrt_cyc[(base + 2) % 64] >= 255) &&
                       (err_cyc - wrt_cyc[(base + 2) % 64] <= 258)}, 32'd1);
        wait_round("to");
        chk_regs("to", 12'h1A1, 12'h255, 12'h3A3, 12'h4A4);
        chk_eq("to_err_sticky", {31'd0, a2d_err}, 32'd1);
        chk_eq("to_cmd_after_skip", {16'd0, wrt_cmd[(base + 3) % 64]}, 32'h1800);
        mute_ch = -1;
`else
        chk_eq("no_timeout_err", {31'd0, a2d_err}, 32'd0);
`endif

        // Reset while waiting on channel-4 read data
        resp_tab[0] = 16'h0A0A; resp_tab[1] = 16'h0B0B;
        resp_tab[3] = 16'h0C0C; resp_tab[4] = 16'h0D0D;
        base = wrt_cnt; rb = rd_cnt;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clk); #2;
            if (wrt_cnt - base >= 8) found = 1'b1;
        end
        chk_eq("rst_mid_reached_rd3", {31'd0, found}, 32'd1);
        repeat (5) @(posedge clk);
        #2;
        chk_eq("rst_mid_no_round_done", rd_cnt - rb, 32'd0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_first_wrt("post_rst");
        wait_round("post_rst");
        chk_regs("post_rst", 12'hA0A, 12'hB0B, 12'hC0C, 12'hD0D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
        $finish;
    end

endmodule
